noc_transfer_arbiter: RTL
=========================

// Module: noc_transfer_arbiter
// PURPOSE
//  Central bus master for the 4-processor NoC. Takes request/destination pairs from every
//  Processing_unit and grants one at a time, round-robin. Drives each unit's master_response
//  input. Muxes the granted unit's 9-bit {tlast,payload} stream onto the router path.
//  Holds the grant until the burst ends (tlast) or a watchdog timeout fires.
// PARAMETERS
//  NUM_PROC   4    number of requesting processors (== 2**DEST_W)
//  DEST_W     2    destination index width
//  DATA_W     9    stream word width; bit DATA_W-1 is tlast
//  TIMEOUT    255  max XFER cycles without tlast before forced release (8-bit counter)
// PORTS
//  clock           in   1                  system clock, rising edge
//  reset           in   1                  asynchronous, active-high
//  req             in   NUM_PROC           request_transfer from each processor
//  dest            in   NUM_PROC*DEST_W    which_processor from each; slice i = [i*DEST_W +: DEST_W]
//  data_in         in   NUM_PROC*DATA_W    data_to_router from each; slice i = [i*DATA_W +: DATA_W]
//  master_response out  NUM_PROC           one-hot, 1-cycle grant pulse to the granted processor
//  route_valid     out  1                  router path owned; data_out is meaningful
//  route_src       out  DEST_W             granted source index
//  route_dst       out  DEST_W             latched destination index
//  data_out        out  DATA_W             data_in slice of route_src when route_valid, else 0
//  busy            out  1                  state != IDLE
//  timeout_err     out  1                  1-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. rr_ptr=NUM_PROC-1, so proc 0 has first priority.
//    Reset mid-transfer aborts immediately with no timeout_err.
//  Eligible request: req[i]=1 and dest slice i != i. A self-addressed request is never granted.
//  FSM (all outputs registered except data_out, which is a combinational mux):
//   IDLE  -> GRANT when any request is eligible.
//            Winner = first eligible index scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_PROC).
//            Latch route_src=winner and route_dst=dest[winner].
//   GRANT -> XFER unconditionally after 1 cycle.
//            master_response[winner]=1 for exactly this cycle.
//            route_valid rises in this cycle; wdog=0.
//   XFER  -> DRAIN when data_in[src][DATA_W-1]=1 (tlast seen).
//         -> IDLE when wdog==TIMEOUT, pulsing timeout_err.
//            Otherwise wdog++. wdog saturates and never wraps.
//   DRAIN -> IDLE after 1 cycle; route_valid stays 1 so the word following tlast is forwarded.
//            rr_ptr=route_src on the DRAIN->IDLE edge and also on timeout release.
//  route_valid=1 in GRANT, XFER and DRAIN; it drops in the same edge that enters IDLE.
//  Latency: req rising before edge n -> master_response high in cycle n+1.
//    Back-to-back grants have a minimum gap of 1 IDLE cycle.
//  Request changes during GRANT/XFER/DRAIN are ignored; route_dst stays latched.
//  Simultaneous requests: only one grant per arbitration; the loser keeps req high and wins next.
//  A requester deasserting req before grant simply drops out; no grant is issued to it.
//  tlast in GRANT cycle is ignored; only XFER samples tlast.
// STRUCTURE
//  noc_pkg holds:
//    - NUM_PROC, DEST_W, DATA_W localparams
//    - state enum: IDLE=2'd0, GRANT=2'd1, XFER=2'd2, DRAIN=2'd3
//    - TLAST_BIT = DATA_W-1
//  Sub-module rr_arbiter (combinational): inputs eligible mask and rr_ptr;
//    outputs one-hot grant and binary index.
//  FSM, watchdog, latches and data mux live in this module.
// TESTING
//  1 Single req: req=0001, dest0=2, tb_len=4 -> master_response=0001 for 1 cycle;
//    route_src=0, route_dst=2; data_out follows proc0; release after tlast+1 cycle.
//  2 Contention: req=1111 held, all dests valid -> grant order 0,1,2,3,0;
//    each grant is a 1-cycle pulse; no overlap of route_valid.
//  3 Self-address: req=0100 with dest2=2 -> no grant and busy=0 forever.
//    Then set dest2=1 -> grant to proc 2.
//  4 Watchdog: granted source never raises tlast -> timeout_err pulses exactly 256 cycles
//    after entering XFER; next request then grants normally.
//  5 Reset mid-XFER: assert reset -> all outputs 0 asynchronously, no timeout_err;
//    after release proc0 wins a 1111 request.
//  6 tlast at counter wrap: tb_len=255 -> DRAIN entered on the tlast word; route_valid drops 2 cycles later.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared widths, watchdog limit and FSM state encoding for the NoC transfer arbiter.
package noc_pkg;

    localparam int NUM_PROC  = 4;
    localparam int DEST_W    = 2;
    localparam int DATA_W    = 9;
    localparam int TLAST_BIT = DATA_W - 1;
    localparam int WDOG_W    = 8;

    localparam logic [WDOG_W-1:0] TIMEOUT = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after rr_ptr, wrapping
// modulo NUM_PROC, returned both one-hot and as a binary index.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PROC-1:0] eligible,
    input  logic [DEST_W-1:0]   rr_ptr,
    output logic [NUM_PROC-1:0] grant,
    output logic [DEST_W-1:0]   grant_idx
);

    logic              found;
    logic [DEST_W-1:0] cand;

    // NUM_PROC == 2**DEST_W, so the index sum wraps naturally; k == NUM_PROC revisits rr_ptr last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_PROC; k++) begin
            cand = rr_ptr + DEST_W'(k);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/noc_transfer_arbiter.sv
// Central NoC bus master: round-robin grants to one processor at a time and muxes its
// {tlast,payload} stream onto the router path until tlast or the watchdog releases it.
module noc_transfer_arbiter
    import noc_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        req,
    input  logic [NUM_PROC*DEST_W-1:0] dest,
    input  logic [NUM_PROC*DATA_W-1:0] data_in,
    output logic [NUM_PROC-1:0]        master_response,
    output logic                       route_valid,
    output logic [DEST_W-1:0]          route_src,
    output logic [DEST_W-1:0]          route_dst,
    output logic [DATA_W-1:0]          data_out,
    output logic                       busy,
    output logic                       timeout_err
);

    logic [DEST_W-1:0] dest_arr [NUM_PROC];
    logic [DATA_W-1:0] data_arr [NUM_PROC];
    logic [NUM_PROC-1:0] eligible;
    logic [NUM_PROC-1:0] win_grant;
    logic [DEST_W-1:0]   win_idx;
    logic                tlast;

    state_t              state_q, state_d;
    logic [DEST_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DEST_W-1:0]   src_q, src_d;
    logic [DEST_W-1:0]   dst_q, dst_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [NUM_PROC-1:0] master_response_q, master_response_d;
    logic                route_valid_q, route_valid_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    // A processor addressing itself is never eligible.
    for (genvar i = 0; i < NUM_PROC; i++) begin : g_unpack
        assign dest_arr[i] = dest[i*DEST_W +: DEST_W];
        assign data_arr[i] = data_in[i*DATA_W +: DATA_W];
        assign eligible[i] = req[i] && (dest_arr[i] != DEST_W'(i));
    end

    rr_arbiter u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (win_grant),
        .grant_idx (win_idx)
    );

    assign tlast = data_arr[src_q][TLAST_BIT];

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        src_d             = src_q;
        dst_d             = dst_q;
        wdog_d            = wdog_q;
        master_response_d = '0;
        timeout_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d           = GRANT;
                    src_d             = win_idx;
                    dst_d             = dest_arr[win_idx];
                    master_response_d = win_grant;
                end
            end
            GRANT: begin
                state_d = XFER;
                wdog_d  = '0;
            end
            XFER: begin
                // tlast wins over the watchdog when both land on the same cycle.
                if (tlast) begin
                    state_d = DRAIN;
                end else if (wdog_q == TIMEOUT) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = src_q;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            DRAIN: begin
                state_d  = IDLE;
                rr_ptr_d = src_q;
            end
            default: state_d = IDLE;
        endcase
        route_valid_d = (state_d != IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            rr_ptr_q          <= DEST_W'(NUM_PROC - 1);
            src_q             <= '0;
            dst_q             <= '0;
            wdog_q            <= '0;
            master_response_q <= '0;
            route_valid_q     <= 1'b0;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            src_q             <= src_d;
            dst_q             <= dst_d;
            wdog_q            <= wdog_d;
            master_response_q <= master_response_d;
            route_valid_q     <= route_valid_d;
            busy_q            <= busy_d;
            timeout_err_q     <= timeout_err_d;
        end
    end

    assign master_response = master_response_q;
    assign route_valid     = route_valid_q;
    assign route_src       = src_q;
    assign route_dst       = dst_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
    assign data_out        = route_valid_q ? data_arr[src_q] : '0;

endmodule
